pkt_fifo: RTL and testbench

- Parametrised successor to the fixed 16-bit tx/rx FIFOs between spi_ctl, softmax_top and uart_ctl.
- Single-clock FIFO, generic width and depth, two read ports:
  - word-level first-word-fall-through (FWFT) port.
  - packet port that exposes and pops PKT_WORDS entries at once, e.g. 8x16 b = 128 b softmax/UART packet.
- Adds level count, almost-full/almost-empty thresholds and sticky overflow/underflow flags.

---
 rtl/pkt_fifo_pkg.sv | 24 ++
 rtl/pkt_fifo_mem.sv | 32 +++
 rtl/pkt_fifo.sv | 129 ++++++++++++
 tb/tb_pkt_fifo.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/pkt_fifo_pkg.sv
// Shared constants, level-width helper and read-count encoding for pkt_fifo.
// No logic; types and constants only.
// Imported by pkt_fifo and pkt_fifo_mem.
package pkt_fifo_pkg;

  localparam int DEF_DATA_W    = 16;
  localparam int DEF_DEPTH     = 16;
  localparam int DEF_PKT_WORDS = 8;
  localparam int DEF_AF_LEVEL  = 14;
  localparam int DEF_AE_LEVEL  = 2;

  // Occupancy needs one bit more than a pointer so that "full" is representable.
  function automatic int lvl_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

  // How many words leave the FIFO this cycle.
  typedef enum logic [1:0] {
    RD_NONE = 2'd0,
    RD_WORD = 2'd1,
    RD_PKT  = 2'd2
  } rd_sel_e;

endpackage

// File: rtl/pkt_fifo_mem.sv
// Storage array: DEPTH x DATA_W registers, one write port, PKT_WORDS read taps.
// Latency: write lands on the clock edge; read taps are combinational.
// Backpressure: none here; the caller only asserts we when the write is accepted.
module pkt_fifo_mem
  import pkt_fifo_pkg::*;
#(
  parameter int DATA_W    = DEF_DATA_W,
  parameter int DEPTH     = DEF_DEPTH,
  parameter int PKT_WORDS = DEF_PKT_WORDS,
  parameter int AW        = $clog2(DEPTH)
) (
  input  logic                          clk,
  input  logic                          we,
  input  logic [AW-1:0]                 waddr,
  input  logic [DATA_W-1:0]             wdata,
  input  logic [AW-1:0]                 raddr,
  output logic [DATA_W*PKT_WORDS-1:0]   rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  // Contents are deliberately not reset; only occupancy decides what is valid.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Tap i reads the i-th oldest word; the AW-bit sum wraps modulo DEPTH.
  for (genvar g = 0; g < PKT_WORDS; g++) begin : g_tap
    assign rdata[g*DATA_W +: DATA_W] = mem[raddr + AW'(g)];
  end

endmodule

// File: rtl/pkt_fifo.sv
// Single-clock FIFO with FWFT word port and PKT_WORDS-wide packet port; optional flush via PKT_FIFO_FLUSH_EN.
// Latency: a written word is visible on rd_data/pkt_data the cycle after the write; reads are zero-latency.
// Backpressure: full/pkt_valid/empty gate acceptance; illegal pushes/pops are dropped and latched in sticky flags.
module pkt_fifo
  import pkt_fifo_pkg::*;
#(
  parameter int DATA_W    = DEF_DATA_W,
  parameter int DEPTH     = DEF_DEPTH,
  parameter int PKT_WORDS = DEF_PKT_WORDS,
  parameter int AF_LEVEL  = DEF_AF_LEVEL,
  parameter int AE_LEVEL  = DEF_AE_LEVEL
) (
  input  logic                         clk,
  input  logic                         rst,
`ifdef PKT_FIFO_FLUSH_EN
  input  logic                         flush,
`endif
  input  logic                         wr_en,
  input  logic [DATA_W-1:0]            wr_data,
  output logic                         full,
  output logic                         almost_full,
  input  logic                         rd_en,
  output logic [DATA_W-1:0]            rd_data,
  output logic                         empty,
  output logic                         almost_empty,
  input  logic                         pkt_rd_en,
  output logic                         pkt_valid,
  output logic [DATA_W*PKT_WORDS-1:0]  pkt_data,
  output logic [lvl_w(DEPTH)-1:0]      level,
  output logic                         overflow,
  output logic                         underflow,
  input  logic                         clr_err
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = lvl_w(DEPTH);

  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          flush_now;
  logic          wr_acc;
  logic          ovf_set;
  logic          unf_set;
  rd_sel_e       rd_sel;
  logic [LW-1:0] rd_cnt;
  logic [LW-1:0] level_nxt;

`ifdef PKT_FIFO_FLUSH_EN
  assign flush_now = flush;
`else
  assign flush_now = 1'b0;
`endif

  // Status flags all come from the registered level.
  assign full         = (level == LW'(DEPTH));
  assign almost_full  = (level >= LW'(AF_LEVEL));
  assign empty        = (level == '0);
  assign almost_empty = (level <= LW'(AE_LEVEL));
  assign pkt_valid    = (level >= LW'(PKT_WORDS));

  // Decide what is accepted this cycle; packet read outranks word read, flush outranks both.
  always_comb begin
    wr_acc  = wr_en & ~full & ~flush_now;
    ovf_set = wr_en & full & ~flush_now;
    rd_sel  = RD_NONE;
    unf_set = 1'b0;
    if (!flush_now) begin
      if (pkt_rd_en) begin
        if (pkt_valid) rd_sel = RD_PKT;
        else           unf_set = 1'b1;
      end else if (rd_en) begin
        if (!empty) rd_sel = RD_WORD;
        else        unf_set = 1'b1;
      end
    end
    case (rd_sel)
      RD_WORD: rd_cnt = LW'(1);
      RD_PKT:  rd_cnt = LW'(PKT_WORDS);
      default: rd_cnt = '0;
    endcase
    level_nxt = level + LW'(wr_acc) - rd_cnt;
  end

  // Pointers and occupancy; reset beats flush, flush beats normal traffic.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else if (flush_now) begin
      rd_ptr <= wr_ptr;
      level  <= '0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + AW'(1);
      rd_ptr <= rd_ptr + rd_cnt[AW-1:0];
      level  <= level_nxt;
    end
  end

  // Sticky error flags: a new event beats clr_err in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (ovf_set)      overflow <= 1'b1;
      else if (clr_err) overflow <= 1'b0;
      if (unf_set)      underflow <= 1'b1;
      else if (clr_err) underflow <= 1'b0;
    end
  end

  pkt_fifo_mem #(
    .DATA_W    (DATA_W),
    .DEPTH     (DEPTH),
    .PKT_WORDS (PKT_WORDS),
    .AW        (AW)
  ) u_mem (
    .clk   (clk),
    .we    (wr_acc & ~rst),
    .waddr (wr_ptr),
    .wdata (wr_data),
    .raddr (rd_ptr),
    .rdata (pkt_data)
  );

  assign rd_data = pkt_data[DATA_W-1:0];

endmodule

// File: tb/tb_pkt_fifo.sv
// Self-checking bench for pkt_fifo with a queue-based reference model.
// Inputs driven after the rising edge; outputs sampled 1 time unit after it.
// Expected words are pushed on accepted writes and popped when the FIFO pops.
module tb_pkt_fifo;

  localparam int DW = 16;
  localparam int PW = 8;

  logic          clk = 1'b0;
  logic          rst, wr_en, rd_en, pkt_rd_en, clr_err, flush;
  logic [DW-1:0] wr_data;
  logic          full, almost_full, empty, almost_empty, pkt_valid;
  logic          overflow, underflow;
  logic [DW-1:0] rd_data;
  logic [DW*PW-1:0] pkt_data;
  logic [4:0]    level;

  logic [DW-1:0] sb[$];
  logic          m_ovf, m_unf;
  int            checks = 0;
  int            errors = 0;

  always #5 clk = ~clk;

  pkt_fifo dut (
    .clk          (clk),
    .rst          (rst),
`ifdef PKT_FIFO_FLUSH_EN
    .flush        (flush),
`endif
    .wr_en        (wr_en),
    .wr_data      (wr_data),
    .full         (full),
    .almost_full  (almost_full),
    .rd_en        (rd_en),
    .rd_data      (rd_data),
    .empty        (empty),
    .almost_empty (almost_empty),
    .pkt_rd_en    (pkt_rd_en),
    .pkt_valid    (pkt_valid),
    .pkt_data     (pkt_data),
    .level        (level),
    .overflow     (overflow),
    .underflow    (underflow),
    .clr_err      (clr_err)
  );

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  // Compare every observable output against the model.
  task automatic check_all(input string tag);
    logic [DW*PW-1:0] exp_pkt;
    int n;
    n = sb.size();
    chk({tag, ".level"}, 128'(level), 128'(n));
    chk({tag, ".empty"}, 128'(empty), 128'(n == 0));
    chk({tag, ".full"},  128'(full),  128'(n == 16));
    chk({tag, ".af"},    128'(almost_full),  128'(n >= 14));
    chk({tag, ".ae"},    128'(almost_empty), 128'(n <= 2));
    chk({tag, ".pv"},    128'(pkt_valid),    128'(n >= PW));
    chk({tag, ".ovf"},   128'(overflow),  128'(m_ovf));
    chk({tag, ".unf"},   128'(underflow), 128'(m_unf));
    if (n > 0) chk({tag, ".rd_data"}, 128'(rd_data), 128'(sb[0]));
    if (n >= PW) begin
      for (int i = 0; i < PW; i++) exp_pkt[i*DW +: DW] = sb[i];
      chk({tag, ".pkt_data"}, 128'(pkt_data), 128'(exp_pkt));
    end
  endtask

  // One clock: drive inputs, advance model with pre-edge state, then compare.
  task automatic step(input string tag, input logic r, input logic w, input logic [DW-1:0] d,
                      input logic rd, input logic prd, input logic clr, input logic fl);
    int  n;
    logic so, su;
    rst = r; wr_en = w; wr_data = d; rd_en = rd; pkt_rd_en = prd; clr_err = clr; flush = fl;
    @(posedge clk);
    #1;
`ifndef PKT_FIFO_FLUSH_EN
    fl = 1'b0;
`endif
    n = sb.size();
    if (r) begin
      sb.delete(); m_ovf = 1'b0; m_unf = 1'b0;
    end else if (fl) begin
      sb.delete();
    end else begin
      so = w && (n == 16);
      su = prd ? (n < PW) : (rd && n == 0);
      if (prd && n >= PW) for (int i = 0; i < PW; i++) void'(sb.pop_front());
      else if (!prd && rd && n > 0) void'(sb.pop_front());
      if (w && n < 16) sb.push_back(d);
      m_ovf = so ? 1'b1 : (clr ? 1'b0 : m_ovf);
      m_unf = su ? 1'b1 : (clr ? 1'b0 : m_unf);
    end
    check_all(tag);
  endtask

  task automatic wr(input string tag, input logic [DW-1:0] d);
    step(tag, 0, 1, d, 0, 0, 0, 0);
  endtask

  initial begin
    m_ovf = 0; m_unf = 0;
    step("reset", 1, 0, '0, 0, 0, 0, 0);

    // Fill to full, then one dropped write.
    for (int i = 1; i <= 16; i++) wr("fill", DW'(i));
    chk("full_pkt", 128'(pkt_data), 128'h0008_0007_0006_0005_0004_0003_0002_0001);
    wr("ovf", 16'hDEAD);
    chk("ovf_level", 128'(level), 128'd16);

    // Packet pop from full.
    step("pkt_pop", 0, 0, '0, 0, 1, 0, 0);
    chk("after_pkt_rd", 128'(rd_data), 128'h0009);
    step("clr", 0, 0, '0, 0, 0, 1, 0);

    // Wrap-around packet view.
    step("rst2", 1, 0, '0, 0, 0, 0, 0);
    for (int i = 0; i < 12; i++) wr("w12", 16'h0100 + DW'(i));
    for (int i = 0; i < 10; i++) step("r10", 0, 0, '0, 1, 0, 0, 0);
    for (int i = 0; i < 6; i++)  wr("w6", 16'h0200 + DW'(i));
    chk("wrap_level", 128'(level), 128'd8);
    step("wrap_pop", 0, 0, '0, 0, 1, 0, 0);

    // Underflow on empty and clr_err priority.
    step("unf_empty", 0, 0, '0, 1, 0, 0, 0);
    step("unf_clr_rd", 0, 0, '0, 1, 0, 1, 0);
    step("unf_clr", 0, 0, '0, 0, 0, 1, 0);

    // Level 5: both reads -> packet underflow, no word pop.
    for (int i = 0; i < 5; i++) wr("w5", 16'h0300 + DW'(i));
    step("both_l5", 0, 0, '0, 1, 1, 0, 0);
    chk("both_l5_lvl", 128'(level), 128'd5);
    step("clr2", 0, 0, '0, 0, 0, 1, 0);
    for (int i = 0; i < 3; i++) wr("w3", 16'h0400 + DW'(i));
    step("both_wr_l8", 0, 1, 16'hBEEF, 1, 1, 0, 0);
    chk("both_wr_lvl", 128'(level), 128'd1);

    // Reset beats a write at level 9.
    for (int i = 0; i < 8; i++) wr("w8", 16'h0500 + DW'(i));
    step("rst_wr", 1, 1, 16'hCAFE, 0, 0, 0, 0);

`ifdef PKT_FIFO_FLUSH_EN
    step("fl_unf", 0, 0, '0, 1, 0, 0, 0);
    for (int i = 0; i < 7; i++) wr("w7", 16'h0600 + DW'(i));
    step("flush", 0, 1, 16'hF00D, 1, 0, 0, 1);
    wr("post_fl", 16'h0777);
    step("post_fl_rd", 0, 0, '0, 1, 0, 1, 0);
`endif

    // Random traffic against the model.
    for (int i = 0; i < 400; i++) begin
      step("rand", ($urandom_range(0, 99) == 0), ($urandom_range(0, 99) < 55), DW'($urandom),
           ($urandom_range(0, 99) < 35), ($urandom_range(0, 99) < 8),
           ($urandom_range(0, 99) < 10), 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
